// File: rtl/food_ctrl.sv
// food_ctrl: food placement, eat detection and BCD scoring for the snake game.
//
// Purpose:
//   Asks the random box generator for a candidate position (drive), waits
//   RAND_LAT cycles for it to settle, checks it against the snake body with
//   an occupancy handshake, and publishes the first free position as food.
//   When the head lands on the food it pulses eat, bumps the BCD score and
//   starts the next placement. After MAX_RETRY occupied candidates in a row
//   it gives up and raises the sticky no_space flag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   game_start          pulse: clear score/flags, (re)start placement
//   move_tick           pulse: head_x/head_y carry a new head position
//   head_x, head_y      snake head position
//   box_x, box_y        candidate position from the generator
//   drive               pulse to the generator for a new candidate
//   occ_req/occ_x/occ_y occupancy query, held until occ_ack
//   occ_ack, occ_hit    query result (occ_hit valid with occ_ack)
//   food_x/food_y       accepted food position
//   food_valid          food is displayed and edible
//   eat                 pulse: head ate the food
//   score               3-digit BCD score, saturates at 999
//   no_space            sticky: placement failed MAX_RETRY times
module food_ctrl #(
  parameter int unsigned RAND_LAT   = 4,
  parameter int unsigned MAX_RETRY  = 8,
  parameter int unsigned SCORE_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_start,
  input  logic        move_tick,
  input  logic [9:0]  head_x,
  input  logic [9:0]  head_y,
  input  logic [9:0]  box_x,
  input  logic [9:0]  box_y,
  output logic        drive,
  output logic        occ_req,
  output logic [9:0]  occ_x,
  output logic [9:0]  occ_y,
  input  logic        occ_ack,
  input  logic        occ_hit,
  output logic [9:0]  food_x,
  output logic [9:0]  food_y,
  output logic        food_valid,
  output logic        eat,
  output logic [11:0] score,
  output logic        no_space
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, QUERY, ARMED} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    wait_reg, wait_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic [9:0]    occ_x_reg, occ_x_next, occ_y_reg, occ_y_next;
  logic [9:0]    food_x_reg, food_x_next, food_y_reg, food_y_next;
  logic          food_valid_reg, food_valid_next;
  logic          eat_reg, eat_next;
  logic [11:0]   score_reg, score_next;
  logic          no_space_reg, no_space_next;
  logic [RW-1:0] retry_inc;

  // BCD add of SCORE_STEP with per-digit carry; any overflow out of the
  // hundreds digit pins the score at 999.
  function automatic logic [11:0] bcd_step(input logic [11:0] s);
    logic [4:0] u;
    logic [3:0] t, h;
    logic       sat;
    u   = {1'b0, s[3:0]} + 5'(SCORE_STEP);
    t   = s[7:4];
    h   = s[11:8];
    sat = 1'b0;
    if (u > 5'd9) begin
      u = u - 5'd10;
      if (t == 4'd9) begin
        t = 4'd0;
        if (h == 4'd9) sat = 1'b1;
        else           h = h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end
    return sat ? 12'h999 : {h, t, u[3:0]};
  endfunction

  assign retry_inc = retry_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wait_reg       <= '0;
      retry_reg      <= '0;
      occ_x_reg      <= '0;
      occ_y_reg      <= '0;
      food_x_reg     <= '0;
      food_y_reg     <= '0;
      food_valid_reg <= 1'b0;
      eat_reg        <= 1'b0;
      score_reg      <= 12'h000;
      no_space_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wait_reg       <= wait_next;
      retry_reg      <= retry_next;
      occ_x_reg      <= occ_x_next;
      occ_y_reg      <= occ_y_next;
      food_x_reg     <= food_x_next;
      food_y_reg     <= food_y_next;
      food_valid_reg <= food_valid_next;
      eat_reg        <= eat_next;
      score_reg      <= score_next;
      no_space_reg   <= no_space_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wait_next       = wait_reg;
    retry_next      = retry_reg;
    occ_x_next      = occ_x_reg;
    occ_y_next      = occ_y_reg;
    food_x_next     = food_x_reg;
    food_y_next     = food_y_reg;
    food_valid_next = food_valid_reg;
    eat_next        = 1'b0;
    score_next      = score_reg;
    no_space_next   = no_space_reg;

    if (game_start) begin
      // Restart from anywhere. A start landing on the REQ cycle reuses the
      // drive pulse already on the wire, so drive never goes back-to-back.
      score_next      = 12'h000;
      no_space_next   = 1'b0;
      retry_next      = '0;
      food_valid_next = 1'b0;
      wait_next       = 4'(RAND_LAT);
      state_next      = (state_reg == REQ) ? WAIT : REQ;
    end else begin
      case (state_reg)
        IDLE: ;
        REQ: begin
          wait_next  = 4'(RAND_LAT);
          state_next = WAIT;
        end
        WAIT: begin
          if (wait_reg == 4'd1) begin
            occ_x_next = box_x;
            occ_y_next = box_y;
            state_next = QUERY;
          end else begin
            wait_next = wait_reg - 4'd1;
          end
        end
        QUERY: begin
          if (occ_ack) begin
            if (!occ_hit) begin
              food_x_next     = occ_x_reg;
              food_y_next     = occ_y_reg;
              food_valid_next = 1'b1;
              retry_next      = '0;
              state_next      = ARMED;
            end else if (retry_inc == RW'(MAX_RETRY)) begin
              retry_next      = retry_inc;
              no_space_next   = 1'b1;
              food_valid_next = 1'b0;
              state_next      = IDLE;
            end else begin
              retry_next = retry_inc;
              state_next = REQ;
            end
          end
        end
        ARMED: begin
          if (move_tick && head_x == food_x_reg && head_y == food_y_reg) begin
            eat_next        = 1'b1;
            food_valid_next = 1'b0;
            score_next      = bcd_step(score_reg);
            state_next      = REQ;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign drive      = (state_reg == REQ);
  assign occ_req    = (state_reg == QUERY);
  assign occ_x      = occ_x_reg;
  assign occ_y      = occ_y_reg;
  assign food_x     = food_x_reg;
  assign food_y     = food_y_reg;
  assign food_valid = food_valid_reg;
  assign eat        = eat_reg;
  assign score      = score_reg;
  assign no_space   = no_space_reg;

endmodule

// File: doc/food_ctrl.md
Name: food_ctrl

Overview:
- Downstream consumer of the random food-box generator in the snake game.
- Requests a new food position via the generator's `drive` input and waits for the generator to settle.
- Rejects any position the snake body occupies, using an occupancy query handshake to the snake body store.
- Publishes the accepted food position to the renderer, detects when the snake head eats the food, and keeps the BCD score.

Parameters:
- RAND_LAT, 4, cycles from a drive pulse until box_x/box_y are stable; valid range 1..15.
- MAX_RETRY, 8, consecutive occupied positions tolerated before no_space is declared.
- SCORE_STEP, 1, points added per eat; 1..9, BCD single digit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- game_start  in  1  one-cycle pulse: clear score and flags, start first placement
- move_tick  in  1  one-cycle pulse each time the snake head has moved
- head_x  in  10  snake head x, valid when move_tick=1
- head_y  in  10  snake head y, valid when move_tick=1
- box_x  in  10  candidate x from the generator
- box_y  in  10  candidate y from the generator
- drive  out  1  one-cycle pulse to the generator to produce a new position
- occ_req  out  1  occupancy query request, held until occ_ack
- occ_x  out  10  query x, stable while occ_req=1
- occ_y  out  10  query y, stable while occ_req=1
- occ_ack  in  1  query done, one-cycle pulse
- occ_hit  in  1  1 = position is on the snake body; sampled with occ_ack
- food_x  out  10  accepted food x
- food_y  out  10  accepted food y
- food_valid  out  1  food is displayed and edible
- eat  out  1  one-cycle pulse: head landed on the food (snake grows)
- score  out  12  3-digit BCD score
- no_space  out  1  sticky: placement failed MAX_RETRY times

Behaviour:
- Reset (asynchronous, rst_n=0) and on leaving reset:
  - state=IDLE.
  - drive=0, occ_req=0, food_valid=0, eat=0, no_space=0.
  - food_x=food_y=0, score=12'h000, retry count=0, wait count=0.
- State IDLE: all outputs hold.
  - game_start -> REQ; score cleared, no_space cleared, retry count cleared.
- State REQ (1 cycle): drive=1. -> WAIT. Wait count loaded with RAND_LAT.
- State WAIT: decrement each cycle. At count 1 -> QUERY; box_x/box_y are latched into occ_x/occ_y on that transition.
- State QUERY:
  - occ_req=1 from the first QUERY cycle until the cycle occ_ack is seen.
  - occ_ack with occ_hit=0 -> ARMED:
    - food_x/food_y <= occ_x/occ_y; food_valid=1 from the next cycle.
    - retry count cleared.
  - occ_ack with occ_hit=1: retry count +1.
    - If the new count equals MAX_RETRY -> IDLE with no_space=1 and food_valid=0.
    - Otherwise -> REQ.
  - occ_ack arriving in the same cycle occ_req first rises is legal.
- State ARMED: evaluate only on move_tick=1.
  - head_x==food_x and head_y==food_y:
    - eat=1 the next cycle, for exactly one cycle.
    - food_valid=0 the same cycle eat=1.
    - score += SCORE_STEP in BCD with per-digit carry; saturates at 999 (no wrap).
    - -> REQ.
  - Head does not match food -> stay in ARMED.
- game_start in any non-IDLE state: abort the current activity and restart as from IDLE.
  - Score cleared, no_space cleared, food_valid=0, occ_req dropped, -> REQ.
  - An occ_ack arriving after the abort is ignored.
- move_tick outside ARMED is ignored; it generates no eat.
- drive is never asserted in two consecutive cycles.
- Latency figures:
  - Eat to next food_valid is at least RAND_LAT+3 cycles.
  - game_start to first drive is 1 cycle.
- Score arithmetic: the units digit overflow adds 1 to the tens digit, and the tens digit overflow adds 1 to the hundreds digit. No digit ever holds A–F.

Test Plan:
- Reset then game_start, generator gives (160,120), occ_hit=0 -> drive pulse cycle 1; occ_req with occ_x=160, occ_y=120; food_valid=1 with food=(160,120); score=000.
- Food at (160,120), move_tick with head (150,120) then head (160,120) -> no eat on the first tick; eat pulse one cycle after the second tick; score=001; food_valid=0; new drive follows.
- Score at 009, then eat -> 010. Score at 099, then eat -> 100. Score at 999, then eat -> stays 999 and eat still pulses.
- occ_hit=1 on three candidates, then 0 on the fourth -> exactly 4 drive pulses; food from the fourth candidate; no_space=0.
- MAX_RETRY=8 consecutive hits -> no_space=1, food_valid=0, state IDLE. Next game_start clears no_space and retries.
- game_start asserted mid-QUERY with occ_req=1 -> occ_req drops, the late occ_ack is ignored, drive pulses once more, score=000. Also assert rst_n low mid-ARMED -> all outputs return to reset values immediately.
